// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper: PS/2 scancodes,
// key-latch slots, joystick bit positions and the coin FSM state type.
package arcade_input_pkg;

  // Arrow keys: matched on the low 8 bits only, extended flag ignored
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  // Player 1 buttons (space, left ctrl, left alt, left shift)
  localparam logic [8:0] KEY_SPACE  = 9'h029;
  localparam logic [8:0] KEY_LCTRL  = 9'h014;
  localparam logic [8:0] KEY_LALT   = 9'h011;
  localparam logic [8:0] KEY_LSHIFT = 9'h012;

  // Player 2 cluster (R/F/D/G directions, A/S/Q/W buttons)
  localparam logic [8:0] KEY_R = 9'h02D;
  localparam logic [8:0] KEY_F = 9'h02B;
  localparam logic [8:0] KEY_D = 9'h023;
  localparam logic [8:0] KEY_G = 9'h034;
  localparam logic [8:0] KEY_A = 9'h01C;
  localparam logic [8:0] KEY_S = 9'h01B;
  localparam logic [8:0] KEY_Q = 9'h015;
  localparam logic [8:0] KEY_W = 9'h01D;

  // System keys
  localparam logic [8:0] KEY_1  = 9'h016;
  localparam logic [8:0] KEY_2  = 9'h01E;
  localparam logic [8:0] KEY_3  = 9'h026;
  localparam logic [8:0] KEY_5  = 9'h02E;
  localparam logic [8:0] KEY_6  = 9'h036;
  localparam logic [8:0] KEY_F1 = 9'h005;
  localparam logic [8:0] KEY_F2 = 9'h006;

  // Key latch slots. Player slots follow the control layout {B4,B3,B2,B1,U,D,L,R}
  // so a player's latch byte can be OR-ed straight onto its joystick bits.
  localparam int          NUM_LATCHES = 22;
  localparam logic [4:0]  LI_P1_R     = 5'd0;
  localparam logic [4:0]  LI_P1_L     = 5'd1;
  localparam logic [4:0]  LI_P1_D     = 5'd2;
  localparam logic [4:0]  LI_P1_U     = 5'd3;
  localparam logic [4:0]  LI_P1_B1    = 5'd4;
  localparam logic [4:0]  LI_P1_B2    = 5'd5;
  localparam logic [4:0]  LI_P1_B3    = 5'd6;
  localparam logic [4:0]  LI_P1_B4    = 5'd7;
  localparam logic [4:0]  LI_P2_R     = 5'd8;
  localparam logic [4:0]  LI_P2_L     = 5'd9;
  localparam logic [4:0]  LI_P2_D     = 5'd10;
  localparam logic [4:0]  LI_P2_U     = 5'd11;
  localparam logic [4:0]  LI_P2_B1    = 5'd12;
  localparam logic [4:0]  LI_P2_B2    = 5'd13;
  localparam logic [4:0]  LI_P2_B3    = 5'd14;
  localparam logic [4:0]  LI_P2_B4    = 5'd15;
  localparam logic [4:0]  LI_START1   = 5'd16;
  localparam logic [4:0]  LI_START2   = 5'd17;
  localparam logic [4:0]  LI_COIN1    = 5'd18;
  localparam logic [4:0]  LI_COIN2    = 5'd19;
  // F1/F2 get their own latches so releasing them cannot cancel a held 1/5 key
  localparam logic [4:0]  LI_SC1      = 5'd20;
  localparam logic [4:0]  LI_SC2      = 5'd21;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_e;

  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } key_hit_t;

  // Joystick word bit positions as a function of the button count
  function automatic int JOY_FIRE(input int n);
    return 4 + n;
  endfunction

  function automatic int JOY_START(input int nb);
    return 4 + nb;
  endfunction

  function automatic int JOY_COIN(input int nb);
    return 5 + nb;
  endfunction

  // Map a 9-bit {extended, scancode} to a latch slot; hit=0 for unknown keys
  function automatic key_hit_t key_decode(input logic [8:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = 5'd0;
    if      (code[7:0] == KEY_UP)    r.idx = LI_P1_U;
    else if (code[7:0] == KEY_DOWN)  r.idx = LI_P1_D;
    else if (code[7:0] == KEY_LEFT)  r.idx = LI_P1_L;
    else if (code[7:0] == KEY_RIGHT) r.idx = LI_P1_R;
    else begin
      case (code)
        KEY_SPACE:  r.idx = LI_P1_B1;
        KEY_LCTRL:  r.idx = LI_P1_B2;
        KEY_LALT:   r.idx = LI_P1_B3;
        KEY_LSHIFT: r.idx = LI_P1_B4;
        KEY_R:      r.idx = LI_P2_U;
        KEY_F:      r.idx = LI_P2_D;
        KEY_D:      r.idx = LI_P2_L;
        KEY_G:      r.idx = LI_P2_R;
        KEY_A:      r.idx = LI_P2_B1;
        KEY_S:      r.idx = LI_P2_B2;
        KEY_Q:      r.idx = LI_P2_B3;
        KEY_W:      r.idx = LI_P2_B4;
        KEY_1:      r.idx = LI_START1;
        KEY_2:      r.idx = LI_START2;
        KEY_5:      r.idx = LI_COIN1;
        KEY_6:      r.idx = LI_COIN2;
        KEY_F1:     r.idx = LI_SC1;
        KEY_F2:     r.idx = LI_SC2;
        default:    r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/coin_shaper.sv
// One coin slot: rising-edge detect on the request, fixed-length pulse,
// enforced low gap, and a single-deep pending flag for early requests.
module coin_shaper
  import arcade_input_pkg::*;
#(
  parameter logic [23:0] COIN_PULSE = 24'd4800000,
  parameter logic [23:0] COIN_GAP   = 24'd2400000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_req,
  output logic o_coin
);

  coin_state_e r_state;
  coin_state_e w_state_next;
  logic [23:0] r_cnt;
  logic        r_pending;
  logic        r_req;
  logic        r_req_prev;
  logic        w_edge;
  logic        w_cnt_zero;

  // Register the request, then compare with its previous sample for edges
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_req      <= 1'b0;
      r_req_prev <= 1'b0;
    end else begin
      r_req      <= i_req;
      r_req_prev <= r_req;
    end
  end

  assign w_edge     = r_req & ~r_req_prev;
  assign w_cnt_zero = (r_cnt == 24'd0);

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic; a queued (or coincident) request skips IDLE after the gap
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_edge) w_state_next = PULSE;
      PULSE:   if (w_cnt_zero) w_state_next = GAP;
      GAP:     if (w_cnt_zero) w_state_next = (r_pending | w_edge) ? PULSE : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output: slot is driven high for the whole PULSE state
  always_comb begin
    o_coin = (r_state == PULSE);
  end

  // Down-counter, loaded with length-1 on entry to PULSE or GAP
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 24'd0;
    end else if (w_state_next == PULSE && r_state != PULSE) begin
      r_cnt <= COIN_PULSE - 24'd1;
    end else if (w_state_next == GAP && r_state == PULSE) begin
      r_cnt <= COIN_GAP - 24'd1;
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - 24'd1;
    end
  end

  // Pending flag: saturating single request, consumed when the gap ends
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else if (r_state == GAP && w_cnt_zero) begin
      r_pending <= 1'b0;
    end else if ((r_state == PULSE || r_state == GAP) && w_edge) begin
      r_pending <= 1'b1;
    end
  end

  a_pulse_nonzero: assert property (@(posedge clk_sys) COIN_PULSE != 24'd0)
    else $error("coin_shaper: COIN_PULSE must be non-zero");
  a_gap_nonzero: assert property (@(posedge clk_sys) COIN_GAP != 24'd0)
    else $error("coin_shaper: COIN_GAP must be non-zero");

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade control front end: PS/2 key latches merged with HPS joysticks
// into registered active-high per-player controls, with upright folding,
// shared autofire and two shaped coin slots.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int          NUM_PLAYERS  = 2,
  parameter int          NUM_BUTTONS  = 2,
  parameter logic [23:0] COIN_PULSE   = 24'd4800000,
  parameter logic [23:0] COIN_GAP     = 24'd2400000,
  parameter logic [21:0] AUTOFIRE_DIV = 22'd2000000
) (
  input  logic                                 clk_sys,
  input  logic                                 reset_n,
  input  logic [10:0]                          ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]            joy,
  input  logic                                 cocktail,
  input  logic [NUM_PLAYERS-1:0]               autofire_en,
  input  logic                                 kbd_clear,
  output logic [(4+NUM_BUTTONS)*NUM_PLAYERS-1:0] ctl_out,
  output logic [NUM_PLAYERS-1:0]               start_out,
  output logic [1:0]                           coin_out
);

  localparam int CW = 4 + NUM_BUTTONS;

  logic                   r_tog;
  logic                   r_tog_vld;
  logic                   w_key_event;
  key_hit_t               w_key_hit;
  logic [NUM_LATCHES-1:0] r_keys;
  logic [21:0]            r_af_cnt;
  logic                   r_af_phase;
  logic [CW-1:0]          w_own [NUM_PLAYERS];
  logic [CW*NUM_PLAYERS-1:0] w_ctl_next;
  logic [NUM_PLAYERS-1:0] w_start_next;
  logic [CW*NUM_PLAYERS-1:0] r_ctl;
  logic [NUM_PLAYERS-1:0] r_start;
  logic [1:0]             w_coin_req;
  logic                   w_unused;

  // Toggle tracker; r_tog_vld masks the first post-reset cycle so the
  // initial toggle level is adopted without being seen as an event
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tog     <= 1'b0;
      r_tog_vld <= 1'b0;
    end else begin
      r_tog     <= ps2_key[10];
      r_tog_vld <= 1'b1;
    end
  end

  assign w_key_event = r_tog_vld & (ps2_key[10] ^ r_tog);
  assign w_key_hit   = key_decode(ps2_key[8:0]);

  // Key latches; clear takes priority over a coincident key event
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_keys <= '0;
    end else if (kbd_clear) begin
      r_keys <= '0;
    end else if (w_key_event && w_key_hit.hit) begin
      r_keys[w_key_hit.idx] <= ps2_key[9];
    end
  end

  // Free-running autofire timebase shared by all players
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_af_cnt   <= 22'd0;
      r_af_phase <= 1'b0;
    end else if (r_af_cnt == AUTOFIRE_DIV - 22'd1) begin
      r_af_cnt   <= 22'd0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt   <= r_af_cnt + 22'd1;
    end
  end

  // Per-player merge of joystick and keyboard; only players 1 and 2 have keys
  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_merge
    logic [CW-1:0] w_key_ctl;
    logic          w_key_start;
    if (gi == 0) begin : g_p1
      assign w_key_ctl   = r_keys[CW-1:0];
      assign w_key_start = r_keys[LI_START1] | r_keys[LI_SC1];
    end else if (gi == 1) begin : g_p2
      assign w_key_ctl   = r_keys[8 +: CW];
      assign w_key_start = r_keys[LI_START2] | r_keys[LI_SC2];
    end else begin : g_joy_only
      assign w_key_ctl   = '0;
      assign w_key_start = 1'b0;
    end
    assign w_own[gi]        = joy[16*gi +: CW] | w_key_ctl;
    assign w_start_next[gi] = joy[16*gi + JOY_START(NUM_BUTTONS)] | w_key_start;
  end

  // Upright folding of P2 into P1, then autofire gating of fire[0]
  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_ctl
    logic [CW-1:0] w_fold;
    logic [CW-1:0] w_fire_ctl;
    if (gi == 0 && NUM_PLAYERS > 1) begin : g_fold
      assign w_fold = cocktail ? w_own[0] : (w_own[0] | w_own[1]);
    end else begin : g_nofold
      assign w_fold = w_own[gi];
    end

    // Held fire[0] follows the autofire phase when this player enables it
    always_comb begin
      w_fire_ctl = w_fold;
      w_fire_ctl[JOY_FIRE(0)] = w_fold[JOY_FIRE(0)] & (~autofire_en[gi] | r_af_phase);
    end

    assign w_ctl_next[gi*CW +: CW] = w_fire_ctl;
  end

  // Output register for controls and start buttons
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ctl   <= '0;
      r_start <= '0;
    end else begin
      r_ctl   <= w_ctl_next;
      r_start <= w_start_next;
    end
  end

  assign ctl_out   = r_ctl;
  assign start_out = r_start;

  // Coin requests: even players feed slot 0, odd players slot 1
  always_comb begin
    w_coin_req[0] = r_keys[LI_COIN1] | r_keys[LI_SC1];
    w_coin_req[1] = r_keys[LI_COIN2] | r_keys[LI_SC2];
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_coin_req[p % 2] = w_coin_req[p % 2] | joy[16*p + JOY_COIN(NUM_BUTTONS)];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_coin
    coin_shaper #(
      .COIN_PULSE (COIN_PULSE),
      .COIN_GAP   (COIN_GAP)
    ) u_coin_shaper (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .i_req   (w_coin_req[gi]),
      .o_coin  (coin_out[gi])
    );
  end

  // Joystick bits above coin and spare key slots are intentionally ignored
  assign w_unused = ^{joy, r_keys, cocktail};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: key path latency, joystick
// vector table, autofire, coin shaping/queueing, clear and async reset.
module tb_arcade_input_mapper;

  logic        clk_sys;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [31:0] joy;
  logic        cocktail;
  logic [1:0]  autofire_en;
  logic        kbd_clear;
  logic [11:0] ctl_out;
  logic [1:0]  start_out;
  logic [1:0]  coin_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hi    = 0;
  logic tg  = 1'b0;

  typedef struct {
    logic [31:0] joy;
    logic        cocktail;
    logic [11:0] ctl;
    logic [1:0]  start;
  } vec_t;

  vec_t vecs [9];

  arcade_input_mapper #(
    .NUM_PLAYERS  (2),
    .NUM_BUTTONS  (2),
    .COIN_PULSE   (24'd10),
    .COIN_GAP     (24'd5),
    .AUTOFIRE_DIV (22'd4)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_key     (ps2_key),
    .joy         (joy),
    .cocktail    (cocktail),
    .autofire_en (autofire_en),
    .kbd_clear   (kbd_clear),
    .ctl_out     (ctl_out),
    .start_out   (start_out),
    .coin_out    (coin_out)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Edges since reset release, used to predict the autofire phase
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic key(input logic pressed, input logic [8:0] code);
    tg = ~tg;
    ps2_key = {tg, pressed, code};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // joy = {P2[15:0], P1[15:0]}; per player R0 L1 D2 U3 F0=4 F1=5 start6 coin7
    vecs[0] = '{32'h0000_0000, 1'b1, 12'h000, 2'b00};
    vecs[1] = '{32'h0002_0000, 1'b0, 12'h082, 2'b00};
    vecs[2] = '{32'h0002_0000, 1'b1, 12'h080, 2'b00};
    vecs[3] = '{32'h0000_0018, 1'b1, 12'h018, 2'b00};
    vecs[4] = '{32'h0040_0000, 1'b0, 12'h000, 2'b10};
    vecs[5] = '{32'h0024_0001, 1'b0, 12'h925, 2'b00};
    vecs[6] = '{32'h0024_0001, 1'b1, 12'h901, 2'b00};
    vecs[7] = '{32'hFF00_FF00, 1'b0, 12'h000, 2'b00};
    vecs[8] = '{32'h0000_007F, 1'b0, 12'h03F, 2'b01};

    reset_n = 1'b0; ps2_key = '0; joy = '0; cocktail = 1'b1;
    autofire_en = 2'b00; kbd_clear = 1'b0;
    step(3);
    chk("reset_ctl", ctl_out, 0);
    chk("reset_start", start_out, 0);
    chk("reset_coin", coin_out, 0);
    reset_n = 1'b1;
    step(2);
    chk("no_spurious_event", ctl_out, 0);

    // Key path latency: latch then output register
    key(1'b1, 9'h029);
    step(1); chk("key_b1_press_c1", ctl_out[4], 0);
    step(1); chk("key_b1_press_c2", ctl_out[4], 1);
    key(1'b0, 9'h029);
    step(1); chk("key_b1_rel_c1", ctl_out[4], 1);
    step(1); chk("key_b1_rel_c2", ctl_out[4], 0);
    ps2_key[9] = 1'b1;  // same toggle level: not an event
    step(3); chk("key_resend_same", ctl_out, 0);

    // Extended-space must not alias to space; unknown code ignored
    key(1'b1, 9'h129);
    step(2); chk("key_ext_space_ignored", ctl_out, 0);
    key(1'b1, 9'h0AA);
    step(2); chk("key_unknown_ignored", {start_out, ctl_out}, 0);

    // Extended arrow up, then clear coinciding with a left-arrow press
    key(1'b1, 9'h175);
    step(2); chk("key_up_ext", ctl_out, 12'h008);
    key(1'b1, 9'h06B); kbd_clear = 1'b1;
    step(1); kbd_clear = 1'b0;
    chk("clear_c1", ctl_out, 12'h008);
    step(1); chk("clear_c2", ctl_out, 12'h000);
    step(2); chk("clear_event_dropped", ctl_out, 12'h000);

    // P2 key and upright folding
    key(1'b1, 9'h02D);
    step(2); chk("key_p2_up_cocktail", ctl_out, 12'h200);
    cocktail = 1'b0;
    step(1); chk("key_p2_up_upright", ctl_out, 12'h208);
    key(1'b0, 9'h02D);
    step(2); chk("key_p2_up_release", ctl_out, 12'h000);
    cocktail = 1'b1;

    // Start keys
    key(1'b1, 9'h016);
    step(2); chk("key_start1", start_out, 2'b01);
    key(1'b0, 9'h016);
    step(2); chk("key_start1_rel", start_out, 2'b00);

    // Joystick table, one-cycle latency
    for (int i = 0; i < 9; i++) begin
      joy = vecs[i].joy; cocktail = vecs[i].cocktail;
      step(1);
      chk($sformatf("vec%0d_ctl", i), {20'h0, ctl_out}, {20'h0, vecs[i].ctl});
      chk($sformatf("vec%0d_start", i), {30'h0, start_out}, {30'h0, vecs[i].start});
    end
    joy = '0; cocktail = 1'b1;
    step(1);

    // Autofire: phase toggles every 4 edges, output uses pre-edge phase
    joy = 32'h0000_0010; autofire_en = 2'b01;
    step(1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("autofire_on_%0d", i), ctl_out[4], ((cyc - 1) / 4) % 2);
      step(1);
    end
    autofire_en = 2'b00;
    step(1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("autofire_off_%0d", i), ctl_out[4], 1);
      step(1);
    end
    joy = '0;
    step(2);

    // Coin held for 100 cycles: one 10-cycle pulse starting 2 cycles later
    joy = 32'h0000_0080;
    for (int s = 1; s <= 100; s++) begin
      step(1);
      chk($sformatf("coin_hold_%0d", s), coin_out, (s >= 2 && s <= 11) ? 2'b01 : 2'b00);
    end
    joy = '0;
    step(25);

    // Three edges: second pulse follows after exactly 5 low cycles
    for (int s = 0; s < 40; s++) begin
      joy = (s == 0 || s == 2 || s == 4) ? 32'h0000_0080 : 32'h0;
      step(1);
      chk($sformatf("coin_queue_%0d", s + 1), coin_out,
          (((s + 1) >= 2 && (s + 1) <= 11) || ((s + 1) >= 17 && (s + 1) <= 26)) ? 2'b01 : 2'b00);
    end

    // P2 coin goes to slot 1
    joy = 32'h0080_0000;
    step(2); chk("coin_slot1", coin_out, 2'b10);
    joy = '0;
    step(25);

    // Reset mid-pulse with a pending request queued
    for (int s = 0; s < 5; s++) begin
      joy = (s == 0 || s == 2) ? 32'h0000_0080 : 32'h0;
      step(1);
    end
    chk("coin_pre_reset", coin_out, 2'b01);
    reset_n = 1'b0;
    #1;
    chk("coin_async_drop", coin_out, 2'b00);
    step(2);
    reset_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (coin_out != 2'b00) hi++;
    end
    chk("coin_no_pending_after_reset", hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised control-input front end for Sega System 1 cores and later MiSTer arcade tops.
- Merges PS/2 keyboard events and up to four HPS joysticks into registered, active-high per-player control vectors.
- Adds a coin-pulse shaper with a gap enforcer, per-player autofire and a keyboard-latch clear.
- The top level packs the outputs into the game's active-low INP/DSW bytes.

Parameters:
- NUM_PLAYERS, 2, number of players (1..4).
- NUM_BUTTONS, 2, fire buttons per player (1..4).
- COIN_PULSE, 24'd4800000, coin_out high time in clk_sys cycles (100 ms at 48 MHz).
- COIN_GAP, 24'd2400000, minimum low time between coin pulses.
- AUTOFIRE_DIV, 22'd2000000, clk_sys cycles per autofire half-period.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  async active-low reset.
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- joy  in  16*NUM_PLAYERS  player p occupies [16p+15:16p]. Bits: [0] R, [1] L, [2] D, [3] U, [4+:NUM_BUTTONS] fire, [4+NUM_BUTTONS] start, [5+NUM_BUTTONS] coin.
- cocktail  in  1  0 = upright: P2 controls are OR-ed into P1.
- autofire_en  in  NUM_PLAYERS  per-player autofire enable on button 1.
- kbd_clear  in  1  synchronous clear of all keyboard latches.
- ctl_out  out  (4+NUM_BUTTONS)*NUM_PLAYERS  per player {fire[NUM_BUTTONS-1:0],U,D,L,R}, active high.
- start_out  out  NUM_PLAYERS  start buttons, active high.
- coin_out  out  2  shaped coin slot pulses.

Behaviour:
- Reset: all key latches, outputs, counters and FSMs go to 0/IDLE. Toggle tracker loads ps2_key[10] on the first post-reset cycle, so no spurious event is generated.
- Key event: ps2_key[10] differs from its registered copy. The latch addressed by the scancode takes ps2_key[9]. Unknown codes are ignored.
- Arrows match [7:0] with the extended bit ignored: 75 U, 72 D, 6B L, 74 R. All other keys match the full 9 bits.
- P1 keys: 029 B1, 014 B2, 011 B3, 012 B4.
- P2 keys: 02D U, 02B D, 023 L, 034 R, 01C B1, 01B B2, 015 B3, 01D B4.
- System keys: 016 start1, 01E start2, 02E coin1, 036 coin2, 005 start1+coin1, 006 start2+coin2.
- Players 3 and 4 take joystick input only.
- kbd_clear zeroes every key latch in the same cycle. If kbd_clear and a key event coincide, kbd_clear wins.
- Latency:
  - Joystick bit to ctl_out/start_out: 1 cycle, through the output register.
  - Key event to output: 2 cycles (latch, then output register).
- Upright mode (cocktail=0): P1 output = P1 | P2 controls; P2 outputs are unchanged. Start is never folded.
- Autofire:
  - One free-running counter, shared by all players. It wraps at AUTOFIRE_DIV-1 and toggles af_phase on each wrap.
  - When autofire_en[p] is set, fire[0] = held & af_phase. The counter is not reset when a button is pressed.
- Coin request per slot s: OR of the key latches for slot s and joy coin bits of every player p with p%2==s. Requests are rising-edge detected.
- Coin FSM, one per slot:
  - IDLE: on edge, go to PULSE, load the counter, coin_out=1. coin_out rises 2 cycles after the request first samples high.
  - PULSE: hold for COIN_PULSE cycles, then go to GAP with coin_out=0.
  - GAP: hold for COIN_GAP cycles, then go to IDLE. If pending is set, go directly to PULSE and clear pending.
  - An edge during PULSE or GAP sets pending. pending saturates at 1; further edges are dropped.
- Reset mid-pulse drops coin_out asynchronously and clears pending.
- Counter widths are 24 bits. COIN_PULSE/COIN_GAP values of 0 are illegal and checked by assertion.

Decomposition:
- Package arcade_input_pkg:
  - scancode localparams (KEY_UP, KEY_SPACE, ...).
  - joystick bit-index functions (JOY_FIRE(n), JOY_START, JOY_COIN) as functions of NUM_BUTTONS.
  - coin FSM state enum {IDLE, PULSE, GAP}.
- Sub-module coin_shaper, instantiated twice. It holds the FSM, counter and pending flag for one slot.

Test Plan:
- Key path: reset, then toggle ps2_key to {1,1,0x029}.
  - ctl_out P1 fire[0]=1 exactly 2 cycles later.
  - Toggle with pressed=0: P1 fire[0]=0 exactly 2 cycles later.
  - Re-sending an identical toggle value produces no change.
- Upright fold: cocktail=0, joy P2 bit1=1 → P1 L and P2 L both =1 after 1 cycle. With cocktail=1 only P2 L=1.
- Coin shaping: COIN_PULSE=10, COIN_GAP=5, joy P1 coin held high for 100 cycles.
  - coin_out[0] is high for exactly 10 cycles, then low.
  - No retrigger while the request stays held.
- Coin queueing: same parameters, 3 request edges within PULSE.
  - Exactly 2 pulses result, separated by exactly 5 low cycles.
- Autofire: AUTOFIRE_DIV=4, autofire_en[0]=1, joy P1 fire0 held → fire[0] alternates with period 8 cycles. With autofire_en=0 it stays 1.
- Clear and reset:
  - Arrow key pressed, then kbd_clear pulse: U=0 two cycles later, with the same-cycle key event ignored.
  - reset_n low mid-PULSE: coin_out=0 immediately, and no pending pulse after release.
